// File: rtl/lipsi_ctrl.sv
// lipsi_ctrl: fetch/decode/execute control FSM for the Lipsi accumulator datapath (optional LIPSI_CTRL_STEP_EN).
// Latency: NOP/ST 2 cycles, BR/ALU-reg/LDR 3, IN 3 plus io wait, ALU-imm 4; HALT is terminal until reset.
// Backpressure: holds in IOWAIT until io_valid; with LIPSI_CTRL_STEP_EN, FETCH holds until step.
module lipsi_ctrl #(
    parameter int         PC_W    = 8,
    parameter logic [7:0] RF_BASE = 8'h00
) (
    input  logic            clk,
    input  logic            rst_n,
`ifdef LIPSI_CTRL_STEP_EN
    input  logic            step,
`endif
    output logic [PC_W-1:0] pmem_addr,
    input  logic [7:0]      pmem_rdata,
    output logic [7:0]      dmem_addr,
    output logic            dmem_rd,
    output logic            dmem_wr,
    output logic [7:0]      dmem_wdata,
    input  logic [7:0]      acc,
    input  logic            acc_zero,
    input  logic            carry,
    output logic [2:0]      alu_op,
    output logic            alu_src_imm,
    output logic [1:0]      mux_sel,
    output logic            acc_we,
    output logic            carry_we,
    output logic [7:0]      imm_out,
    input  logic [7:0]      io_in,
    input  logic            io_valid,
    output logic            io_ready,
    output logic            halted
);

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_OPND, S_IOWAIT, S_EXEC, S_HALT
    } state_t;

    typedef enum logic [2:0] {
        OP_NOP, OP_ALUR, OP_ST, OP_LDR, OP_ALUI, OP_BR, OP_IN, OP_HALT
    } op_t;

    function automatic op_t classify(input logic [7:0] b);
        op_t o;
        o = OP_NOP;
        casez (b)
            8'b0???_????: o = OP_ALUR;
            8'b1000_????: o = OP_ST;
            8'b1001_????: o = OP_LDR;
            8'b1100_0???: o = OP_ALUI;
            8'b1101_00??: o = OP_BR;
            8'b1110_????: o = OP_IN;
            8'b1111_1111: o = OP_HALT;
            default:      o = OP_NOP;
        endcase
        return o;
    endfunction

    state_t          state;
    logic [PC_W-1:0] pc;
    logic [7:0]      ir;
    op_t             dec_op;
    op_t             ir_op;
    logic            br_taken;
    logic            fetch_go;

    assign dec_op = classify(pmem_rdata);
    assign ir_op  = classify(ir);

`ifdef LIPSI_CTRL_STEP_EN
    assign fetch_go = step;
`else
    assign fetch_go = 1'b1;
`endif

    // Flags are sampled in OPND, after any preceding EXEC write has landed.
    always_comb begin
        br_taken = 1'b0;
        case (ir[1:0])
            2'b00: br_taken = 1'b1;
            2'b01: br_taken = acc_zero;
            2'b10: br_taken = !acc_zero;
            2'b11: br_taken = carry;
            default: br_taken = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= S_FETCH;
            pc      <= '0;
            ir      <= 8'h00;
            imm_out <= 8'h00;
        end else begin
            case (state)
                S_FETCH: begin
                    if (fetch_go) begin
                        pc    <= pc + PC_W'(1);
                        state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    ir <= pmem_rdata;
                    case (dec_op)
                        OP_ALUR, OP_LDR: state <= S_EXEC;
                        OP_ALUI, OP_BR: begin
                            pc    <= pc + PC_W'(1);
                            state <= S_OPND;
                        end
                        OP_IN:   state <= S_IOWAIT;
                        OP_HALT: state <= S_HALT;
                        default: state <= S_FETCH;
                    endcase
                end
                S_OPND: begin
                    if (ir_op == OP_ALUI) begin
                        imm_out <= pmem_rdata;
                        state   <= S_EXEC;
                    end else begin
                        if (br_taken) begin
                            pc <= PC_W'(pmem_rdata);
                        end
                        state <= S_FETCH;
                    end
                end
                S_IOWAIT: begin
                    if (io_valid) begin
                        imm_out <= io_in;
                        state   <= S_EXEC;
                    end
                end
                S_EXEC:  state <= S_FETCH;
                S_HALT:  state <= S_HALT;
                default: state <= S_FETCH;
            endcase
        end
    end

    // The program counter doubles as the program-memory address for both opcode and operand fetches.
    assign pmem_addr  = pc;
    assign dmem_wdata = acc;
    assign halted     = (state == S_HALT);

    always_comb begin
        dmem_rd     = 1'b0;
        dmem_wr     = 1'b0;
        dmem_addr   = RF_BASE + {4'h0, ir[3:0]};
        acc_we      = 1'b0;
        carry_we    = 1'b0;
        mux_sel     = 2'b00;
        alu_op      = 3'd0;
        alu_src_imm = 1'b0;
        io_ready    = 1'b0;
        case (state)
            S_DECODE: begin
                dmem_addr = RF_BASE + {4'h0, pmem_rdata[3:0]};
                dmem_rd   = (dec_op == OP_ALUR) || (dec_op == OP_LDR);
                dmem_wr   = (dec_op == OP_ST);
            end
            S_IOWAIT: io_ready = 1'b1;
            S_EXEC: begin
                acc_we = 1'b1;
                case (ir_op)
                    OP_ALUR: begin
                        mux_sel  = 2'b10;
                        carry_we = 1'b1;
                        alu_op   = ir[6:4];
                    end
                    OP_ALUI: begin
                        mux_sel     = 2'b10;
                        carry_we    = 1'b1;
                        alu_op      = ir[2:0];
                        alu_src_imm = 1'b1;
                    end
                    OP_LDR:  mux_sel = 2'b01;
                    default: mux_sel = 2'b00;
                endcase
            end
            default: ;
        endcase
        // Nothing may commit while reset is asserted, even mid-instruction.
        if (!rst_n) begin
            dmem_rd  = 1'b0;
            dmem_wr  = 1'b0;
            acc_we   = 1'b0;
            carry_we = 1'b0;
            io_ready = 1'b0;
        end
    end

endmodule
